// File: rtl/iwdg_wb_master.sv
// Wishbone master that programs the IWDG (unlock, prescaler, reload, status, start)
// and then services it with periodic reload-key writes.
module iwdg_wb_master #(
    parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter logic [2:0]  PR_INIT     = 3'b010,
    parameter logic [11:0] RLR_INIT    = 12'h800,
    parameter int unsigned KICK_PERIOD = 1000,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                  clk_m2s,
    input  logic                  rst_m2s,
    input  logic                  start,
    input  logic                  kick_en,
    input  logic [DATA_WIDTH-1:0] dat_s2m,
    input  logic                  ack_s2m,
    output logic [31:0]           adr_m2s,
    output logic [DATA_WIDTH-1:0] dat_m2s,
    output logic                  cyc_m2s,
    output logic                  stb_m2s,
    output logic                  we_m2s,
    output logic                  cfg_done,
    output logic                  err_timeout,
    output logic [1:0]            st_val,
    output logic [15:0]           kick_cnt
);

    localparam int unsigned KT_W = $clog2(KICK_PERIOD);
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT);

    localparam logic [KT_W-1:0] KICK_LOAD = KT_W'(KICK_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    localparam logic [31:0] ADR_KR  = BASE_ADR;
    localparam logic [31:0] ADR_PR  = BASE_ADR + 32'h4;
    localparam logic [31:0] ADR_RLR = BASE_ADR + 32'h8;
    localparam logic [31:0] ADR_ST  = BASE_ADR + 32'hC;

    localparam logic [DATA_WIDTH-1:0] KEY_ACCESS = DATA_WIDTH'(16'h5555);
    localparam logic [DATA_WIDTH-1:0] KEY_COUNT  = DATA_WIDTH'(16'hCCCC);
    localparam logic [DATA_WIDTH-1:0] KEY_RELOAD = DATA_WIDTH'(16'hAAAA);
    localparam logic [DATA_WIDTH-1:0] PR_DATA    = DATA_WIDTH'(PR_INIT);
    localparam logic [DATA_WIDTH-1:0] RLR_DATA   = DATA_WIDTH'(RLR_INIT);

    typedef enum logic [3:0] {
        IDLE,
        WR_ACCESS,
        WR_PR,
        WR_RLR,
        RD_ST,
        WR_COUNT,
        RUN,
        WR_RELOAD,
        GAP,
        ERROR
    } state_t;

    state_t                r_state, w_state_nxt;
    state_t                r_after, w_after_nxt;
    state_t                w_target;
    logic                  w_launch;
    logic                  w_ack;
    logic                  w_unused_dat;

    logic                  r_cyc, w_cyc_nxt;
    logic                  r_stb, w_stb_nxt;
    logic                  r_we, w_we_nxt;
    logic [31:0]           r_adr, w_adr_nxt;
    logic [DATA_WIDTH-1:0] r_dat, w_dat_nxt;
    logic                  r_cfg_done, w_cfg_done_nxt;
    logic                  r_err, w_err_nxt;
    logic [1:0]            r_st_val, w_st_val_nxt;
    logic [15:0]           r_kick_cnt, w_kick_cnt_nxt;
    logic [KT_W-1:0]       r_kick_tmr, w_kick_tmr_nxt;
    logic [TO_W-1:0]       r_tmo, w_tmo_nxt;

    assign w_ack        = ack_s2m & r_cyc & r_stb;
    assign w_unused_dat = ^dat_s2m[DATA_WIDTH-1:2];

    // Transaction states share one handshake/timeout path; entry into any
    // transaction is funnelled through w_launch/w_target below.
    always_comb begin
        w_state_nxt    = r_state;
        w_after_nxt    = r_after;
        w_cyc_nxt      = r_cyc;
        w_stb_nxt      = r_stb;
        w_we_nxt       = r_we;
        w_adr_nxt      = r_adr;
        w_dat_nxt      = r_dat;
        w_cfg_done_nxt = r_cfg_done;
        w_err_nxt      = r_err;
        w_st_val_nxt   = r_st_val;
        w_kick_cnt_nxt = r_kick_cnt;
        w_kick_tmr_nxt = r_kick_tmr;
        w_tmo_nxt      = r_tmo;
        w_launch       = 1'b0;
        w_target       = WR_ACCESS;

        case (r_state)
            IDLE, ERROR: begin
                if (start) begin
                    w_launch = 1'b1;
                    w_target = WR_ACCESS;
                end
            end
            WR_ACCESS, WR_PR, WR_RLR, RD_ST, WR_COUNT, WR_RELOAD: begin
                if (w_ack) begin
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = GAP;
                    case (r_state)
                        WR_ACCESS: w_after_nxt = WR_PR;
                        WR_PR:     w_after_nxt = WR_RLR;
                        WR_RLR:    w_after_nxt = RD_ST;
                        RD_ST: begin
                            w_after_nxt  = WR_COUNT;
                            w_st_val_nxt = dat_s2m[1:0];
                        end
                        WR_COUNT: begin
                            w_after_nxt    = RUN;
                            w_cfg_done_nxt = 1'b1;
                        end
                        default: begin
                            w_after_nxt = RUN;
                            if (r_kick_cnt != '1) begin
                                w_kick_cnt_nxt = r_kick_cnt + 16'd1;
                            end
                        end
                    endcase
                end else if (r_tmo == TO_LAST) begin
                    w_cyc_nxt      = 1'b0;
                    w_stb_nxt      = 1'b0;
                    w_we_nxt       = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_cfg_done_nxt = 1'b0;
                    w_state_nxt    = ERROR;
                end else begin
                    w_tmo_nxt = r_tmo + TO_W'(1);
                end
            end
            GAP: begin
                if (r_after == RUN) begin
                    w_state_nxt    = RUN;
                    w_kick_tmr_nxt = KICK_LOAD;
                end else begin
                    w_launch = 1'b1;
                    w_target = r_after;
                end
            end
            RUN: begin
                // Timer parks at zero while kicks are disabled.
                if (r_kick_tmr == '0) begin
                    if (kick_en) begin
                        w_launch = 1'b1;
                        w_target = WR_RELOAD;
                    end
                end else begin
                    w_kick_tmr_nxt = r_kick_tmr - KT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_launch) begin
            w_state_nxt = w_target;
            w_cyc_nxt   = 1'b1;
            w_stb_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
            w_tmo_nxt   = '0;
            case (w_target)
                WR_ACCESS: begin
                    w_adr_nxt = ADR_KR;
                    w_dat_nxt = KEY_ACCESS;
                end
                WR_PR: begin
                    w_adr_nxt = ADR_PR;
                    w_dat_nxt = PR_DATA;
                end
                WR_RLR: begin
                    w_adr_nxt = ADR_RLR;
                    w_dat_nxt = RLR_DATA;
                end
                RD_ST: begin
                    w_adr_nxt = ADR_ST;
                    w_dat_nxt = '0;
                    w_we_nxt  = 1'b0;
                end
                WR_COUNT: begin
                    w_adr_nxt = ADR_KR;
                    w_dat_nxt = KEY_COUNT;
                end
                default: begin
                    w_adr_nxt = ADR_KR;
                    w_dat_nxt = KEY_RELOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_m2s) begin
        if (rst_m2s) begin
            r_state    <= IDLE;
            r_after    <= IDLE;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_cfg_done <= 1'b0;
            r_err      <= 1'b0;
            r_st_val   <= '0;
            r_kick_cnt <= '0;
            r_kick_tmr <= '0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_after    <= w_after_nxt;
            r_cyc      <= w_cyc_nxt;
            r_stb      <= w_stb_nxt;
            r_we       <= w_we_nxt;
            r_adr      <= w_adr_nxt;
            r_dat      <= w_dat_nxt;
            r_cfg_done <= w_cfg_done_nxt;
            r_err      <= w_err_nxt;
            r_st_val   <= w_st_val_nxt;
            r_kick_cnt <= w_kick_cnt_nxt;
            r_kick_tmr <= w_kick_tmr_nxt;
            r_tmo      <= w_tmo_nxt;
        end
    end

    assign adr_m2s     = r_adr;
    assign dat_m2s     = r_dat;
    assign cyc_m2s     = r_cyc;
    assign stb_m2s     = r_stb;
    assign we_m2s      = r_we;
    assign cfg_done    = r_cfg_done;
    assign err_timeout = r_err;
    assign st_val      = r_st_val;
    assign kick_cnt    = r_kick_cnt;

endmodule

// File: tb/tb_iwdg_wb_master.sv
// Directed bench for iwdg_wb_master: config sequence, status capture, periodic
// kick, starvation, ack timeout and reset during a transaction.
module tb_iwdg_wb_master;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kick_en = 1'b1;
    logic [15:0] dat_s2m = 16'h0000;
    logic        ack_s2m = 1'b0;
    logic [31:0] adr_m2s;
    logic [15:0] dat_m2s;
    logic        cyc_m2s, stb_m2s, we_m2s;
    logic        cfg_done, err_timeout;
    logic [1:0]  st_val;
    logic [15:0] kick_cnt;

    int checks = 0;
    int failures = 0;

    // Slave model state and transaction log
    logic        noack_en = 1'b0;
    logic [31:0] noack_adr = 32'h0;
    int          ncnt = 0;
    int          s_cnt = 0;
    int          unstable = 0;
    logic [31:0] s_adr;
    logic [15:0] s_dat;
    logic        s_we;
    int          s_start = 0;
    int          log_n = 0;
    logic [31:0] log_adr [128];
    logic [15:0] log_dat [128];
    logic        log_we  [128];
    int          log_s   [128];
    int          log_a   [128];

    iwdg_wb_master #(
        .BASE_ADR   (BASE),
        .DATA_WIDTH (16),
        .PR_INIT    (3'b010),
        .RLR_INIT   (12'h800),
        .KICK_PERIOD(10),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk_m2s    (clk),
        .rst_m2s    (rst),
        .start      (start),
        .kick_en    (kick_en),
        .dat_s2m    (dat_s2m),
        .ack_s2m    (ack_s2m),
        .adr_m2s    (adr_m2s),
        .dat_m2s    (dat_m2s),
        .cyc_m2s    (cyc_m2s),
        .stb_m2s    (stb_m2s),
        .we_m2s     (we_m2s),
        .cfg_done   (cfg_done),
        .err_timeout(err_timeout),
        .st_val     (st_val),
        .kick_cnt   (kick_cnt)
    );

    always #5 clk = ~clk;

    // Slave acks one cycle after strobe, except on the address selected for no-ack
    always @(negedge clk) begin
        ncnt = ncnt + 1;
        if (cyc_m2s && stb_m2s) begin
            if (s_cnt == 0) begin
                s_adr   = adr_m2s;
                s_dat   = dat_m2s;
                s_we    = we_m2s;
                s_start = ncnt;
            end else if (adr_m2s !== s_adr || dat_m2s !== s_dat || we_m2s !== s_we) begin
                unstable = unstable + 1;
            end
            if (s_cnt >= 1 && !(noack_en && adr_m2s == noack_adr) && log_n < 128) begin
                ack_s2m        = 1'b1;
                log_adr[log_n] = adr_m2s;
                log_dat[log_n] = dat_m2s;
                log_we[log_n]  = we_m2s;
                log_s[log_n]   = s_start;
                log_a[log_n]   = ncnt;
                log_n          = log_n + 1;
            end else begin
                ack_s2m = 1'b0;
            end
            s_cnt = s_cnt + 1;
        end else begin
            ack_s2m = 1'b0;
            s_cnt   = 0;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (log_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cyc_m2s, stb_m2s, we_m2s} !== 3'b000) begin
            failures++;
            $display("FAIL reset_bus got=%b exp=000", {cyc_m2s, stb_m2s, we_m2s});
        end
        checks++;
        if (adr_m2s !== 32'h0 || dat_m2s !== 16'h0) begin
            failures++;
            $display("FAIL reset_adr_dat got=%h/%h exp=0/0", adr_m2s, dat_m2s);
        end
        checks++;
        if ({cfg_done, err_timeout, st_val} !== 4'b0000 || kick_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_status got=%b%b%b cnt=%h exp=0000 cnt=0",
                     cfg_done, err_timeout, st_val, kick_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_config();
        logic [31:0] exp_adr [5];
        logic [15:0] exp_dat [5];
        logic        exp_we  [5];
        int base;
        bit ok;
        exp_adr[0] = BASE;         exp_dat[0] = 16'h5555; exp_we[0] = 1'b1;
        exp_adr[1] = BASE + 32'h4; exp_dat[1] = 16'h0002; exp_we[1] = 1'b1;
        exp_adr[2] = BASE + 32'h8; exp_dat[2] = 16'h0800; exp_we[2] = 1'b1;
        exp_adr[3] = BASE + 32'hC; exp_dat[3] = 16'h0000; exp_we[3] = 1'b0;
        exp_adr[4] = BASE;         exp_dat[4] = 16'hCCCC; exp_we[4] = 1'b1;
        base = log_n;
        dat_s2m = 16'h0003;
        pulse_start();
        wait_log(base + 4, 100, ok);
        checks++;
        if (!ok || cfg_done !== 1'b0) begin
            failures++;
            $display("FAIL cfg_before_5th got=ok%0d/done%b exp=ok1/done0", ok, cfg_done);
        end
        wait_log(base + 5, 100, ok);
        checks++;
        if (!ok || cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL cfg_done_5th got=ok%0d/done%b exp=ok1/done1", ok, cfg_done);
        end
        checks++;
        if (st_val !== 2'b11) begin
            failures++;
            $display("FAIL st_capture got=%b exp=11", st_val);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_adr[base+i] !== exp_adr[i] || log_dat[base+i] !== exp_dat[i] ||
                log_we[base+i] !== exp_we[i]) begin
                failures++;
                $display("FAIL cfg_xact%0d got=%h<-%h we%b exp=%h<-%h we%b", i,
                         log_adr[base+i], log_dat[base+i], log_we[base+i],
                         exp_adr[i], exp_dat[i], exp_we[i]);
            end
            checks++;
            if (log_a[base+i] != log_s[base+i] + 1) begin
                failures++;
                $display("FAIL cfg_ack_lat%0d got=%0d exp=%0d", i,
                         log_a[base+i] - log_s[base+i], 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_s[base+i+1] != log_a[base+i] + 2) begin
                failures++;
                $display("FAIL cfg_gap%0d got=%0d exp=%0d", i,
                         log_s[base+i+1] - log_a[base+i], 2);
            end
        end
    endtask

    // RUN lasts 10 cycles after GAP, so each reload starts 12 negedges after the previous ack
    task automatic test_kick();
        int base;
        bit ok;
        base = log_n;
        wait_log(base + 3, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL kick_wait got=%0d exp=%0d", log_n - base, 3);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_adr[base+i] !== BASE || log_dat[base+i] !== 16'hAAAA || log_we[base+i] !== 1'b1) begin
                failures++;
                $display("FAIL kick_xact%0d got=%h<-%h we%b exp=%h<-aaaa we1", i,
                         log_adr[base+i], log_dat[base+i], log_we[base+i], BASE);
            end
            checks++;
            if (log_s[base+i] != log_a[base+i-1] + 12) begin
                failures++;
                $display("FAIL kick_period%0d got=%0d exp=%0d", i,
                         log_s[base+i] - log_a[base+i-1], 12);
            end
        end
        checks++;
        if (kick_cnt !== 16'd3) begin
            failures++;
            $display("FAIL kick_cnt3 got=%0d exp=3", kick_cnt);
        end
    endtask

    task automatic test_starve();
        int n0;
        int busy;
        bit ok;
        @(negedge clk);
        kick_en = 1'b0;
        n0 = log_n;
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = (i == 25);
            if (cyc_m2s || stb_m2s) busy++;
        end
        start = 1'b0;
        checks++;
        if (busy != 0 || log_n != n0) begin
            failures++;
            $display("FAIL starve_idle got=busy%0d/xacts%0d exp=busy0/xacts0", busy, log_n - n0);
        end
        checks++;
        if (kick_cnt !== 16'd3 || cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL starve_status got=cnt%0d/done%b exp=cnt3/done1", kick_cnt, cfg_done);
        end
        kick_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cyc_m2s, stb_m2s, we_m2s} !== 3'b111 || adr_m2s !== BASE || dat_m2s !== 16'hAAAA) begin
            failures++;
            $display("FAIL starve_resume got=%b %h<-%h exp=111 %h<-aaaa",
                     {cyc_m2s, stb_m2s, we_m2s}, adr_m2s, dat_m2s, BASE);
        end
        wait_log(n0 + 1, 20, ok);
        checks++;
        if (!ok || kick_cnt !== 16'd4) begin
            failures++;
            $display("FAIL kick_cnt4 got=ok%0d/cnt%0d exp=ok1/cnt4", ok, kick_cnt);
        end
    endtask

    task automatic test_timeout();
        bit found;
        bit ok;
        int early;
        int base;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        noack_adr = BASE + 32'h4;
        noack_en  = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (cyc_m2s && adr_m2s == BASE + 32'h4) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL tmo_pr_seen got=0 exp=1");
        end
        early = 0;
        for (int j = 1; j < 8; j++) begin
            @(posedge clk);
            #1;
            if (!cyc_m2s) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL tmo_hold got=%0d_dropped exp=0", early);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cyc_m2s, stb_m2s, err_timeout, cfg_done} !== 4'b0010) begin
            failures++;
            $display("FAIL tmo_expire got=%b exp=0010", {cyc_m2s, stb_m2s, err_timeout, cfg_done});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (cyc_m2s !== 1'b0 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL tmo_error_idle got=cyc%b/err%b exp=cyc0/err1", cyc_m2s, err_timeout);
        end
        noack_en = 1'b0;
        base = log_n;
        pulse_start();
        wait_log(base + 5, 100, ok);
        checks++;
        if (!ok || log_adr[base] !== BASE || log_dat[base] !== 16'h5555) begin
            failures++;
            $display("FAIL tmo_restart got=ok%0d %h<-%h exp=ok1 %h<-5555",
                     ok, log_adr[base], log_dat[base], BASE);
        end
        checks++;
        if (cfg_done !== 1'b1 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL tmo_sticky got=done%b/err%b exp=done1/err1", cfg_done, err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit ok;
        int base;
        noack_adr = BASE + 32'h8;
        noack_en  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dat_s2m = 16'h0001;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (cyc_m2s && adr_m2s == BASE + 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_rlr_seen got=0 exp=1");
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cyc_m2s, stb_m2s, we_m2s} !== 3'b000 || adr_m2s !== 32'h0 || dat_m2s !== 16'h0) begin
            failures++;
            $display("FAIL rstmid_bus got=%b %h/%h exp=000 0/0",
                     {cyc_m2s, stb_m2s, we_m2s}, adr_m2s, dat_m2s);
        end
        checks++;
        if ({cfg_done, err_timeout, st_val} !== 4'b0000 || kick_cnt !== 16'h0) begin
            failures++;
            $display("FAIL rstmid_status got=%b%b%b cnt=%h exp=0000 cnt=0",
                     cfg_done, err_timeout, st_val, kick_cnt);
        end
        noack_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base = log_n;
        pulse_start();
        wait_log(base + 5, 100, ok);
        checks++;
        if (!ok || log_dat[base] !== 16'h5555 || log_dat[base+2] !== 16'h0800) begin
            failures++;
            $display("FAIL rstmid_rerun got=ok%0d %h,%h exp=ok1 5555,0800",
                     ok, log_dat[base], log_dat[base+2]);
        end
        checks++;
        if (cfg_done !== 1'b1 || st_val !== 2'b01 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_status2 got=done%b/st%b/err%b exp=done1/st01/err0",
                     cfg_done, st_val, err_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_kick();
        test_starve();
        test_timeout();
        test_reset_mid();
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL bus_stable got=%0d_changes exp=0", unstable);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1, "time limit");
    end

endmodule
